// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a bus-accessible control register.
// Optional leading-zero blanking is compiled in when the macro SEG_LZB_EN is defined.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk_100mhz,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int              PS_W    = $clog2(SCAN_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    logic [1:0]      idx_q, idx_d;
    logic [23:0]     ctrl_q, ctrl_d;
    logic [7:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            scan_adv;
    logic [3:0]      digit_nib;
    logic [3:0]      blank;

    // Reserved write lanes are deliberately dropped.
    logic unused_lanes;
    assign unused_lanes = ^{sel_i[3], data_i[31:24]};

    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_font = 7'h40;
            4'h1:    hex_font = 7'h79;
            4'h2:    hex_font = 7'h24;
            4'h3:    hex_font = 7'h30;
            4'h4:    hex_font = 7'h19;
            4'h5:    hex_font = 7'h12;
            4'h6:    hex_font = 7'h02;
            4'h7:    hex_font = 7'h78;
            4'h8:    hex_font = 7'h00;
            4'h9:    hex_font = 7'h10;
            4'hA:    hex_font = 7'h08;
            4'hB:    hex_font = 7'h03;
            4'hC:    hex_font = 7'h46;
            4'hD:    hex_font = 7'h21;
            4'hE:    hex_font = 7'h06;
            default: hex_font = 7'h0E;
        endcase
    endfunction

    always_comb begin
        scan_adv = (ps_q == PS_LAST);
        ps_d     = scan_adv ? '0 : ps_q + PS_W'(1);
        idx_d    = scan_adv ? idx_q + 2'd1 : idx_q;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        ctrl_d = ctrl_q;
        if (ce_i && we_i) begin
            for (int b = 0; b < 3; b++) begin
                if (sel_i[b]) ctrl_d[8*b +: 8] = data_i[8*b +: 8];
            end
        end
    end

`ifdef SEG_LZB_EN
    always_comb begin : lzb
        logic higher_zero;
        logic zero_k;
        blank       = 4'b0000;
        higher_zero = 1'b1;
        for (int k = 3; k >= 1; k--) begin
            zero_k      = (ctrl_q[4*k +: 4] == 4'h0) && !ctrl_q[16+k];
            blank[k]    = zero_k && higher_zero;
            higher_zero = higher_zero && (!ctrl_q[20+k] || zero_k);
        end
    end
`else
    assign blank = 4'b0000;
`endif

    always_comb begin
        case (idx_q)
            2'd0:    digit_nib = ctrl_q[3:0];
            2'd1:    digit_nib = ctrl_q[7:4];
            2'd2:    digit_nib = ctrl_q[11:8];
            default: digit_nib = ctrl_q[15:12];
        endcase
        seg_d = 8'hFF;
        an_d  = 4'b1111;
        if (ctrl_q[20 + 32'(idx_q)] && !blank[idx_q]) begin
            an_d[idx_q] = 1'b0;
            seg_d       = {~ctrl_q[16 + 32'(idx_q)], hex_font(digit_nib)};
        end
    end

    assign data_o = (ce_i && !we_i) ? {8'h00, ctrl_q} : 32'h0;
    assign seg    = seg_q;
    assign an     = an_q;

    always_ff @(posedge clk_100mhz) begin
        // NOTE: reset is synchronous, so it is only tested inside the clocked block, never in the sensitivity list.
        if (rst) begin
            ps_q   <= '0;
            idx_q  <= 2'd0;
            ctrl_q <= 24'h0;
            seg_q  <= 8'hFF;
            an_q   <= 4'b1111;
        end else begin
            ps_q   <= ps_d;
            idx_q  <= idx_d;
            ctrl_q <= ctrl_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (SCAN_DIV=4) against a cycle-count display model.
// Honours SEG_LZB_EN the same way the design does.
module tb_seg7_scan_ctrl;

    localparam int DIV = 4;

    logic        clk_100mhz = 1'b0;
    logic        rst        = 1'b0;
    logic        ce_i       = 1'b0;
    logic        we_i       = 1'b0;
    logic [3:0]  sel_i      = 4'h0;
    logic [31:0] data_i     = 32'h0;
    logic [31:0] data_o;
    logic [7:0]  seg;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;

    // Model: register contents, edges since reset, and the display expected after the last edge.
    logic [23:0] m_ctrl = 24'h0;
    int          m_cyc  = 0;
    logic [7:0]  exp_seg = 8'hFF;
    logic [3:0]  exp_an  = 4'hF;

    logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg7_scan_ctrl #(.SCAN_DIV(DIV)) dut (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .ce_i       (ce_i),
        .we_i       (we_i),
        .sel_i      (sel_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    function automatic logic [3:0] nib_of(input logic [23:0] c, input int d);
        logic [23:0] sh;
        sh = c >> (4 * d);
        return sh[3:0];
    endfunction

    function automatic logic [11:0] ref_disp(input logic [23:0] c, input int d);
        logic [7:0] s;
        logic       blk;
        if (!c[20+d]) return {8'hFF, 4'hF};
        blk = 1'b0;
`ifdef SEG_LZB_EN
        if (d > 0) begin
            blk = 1'b1;
            for (int j = d; j < 4; j++) begin
                if ((j == d || c[20+j]) && (nib_of(c, j) != 4'h0 || c[16+j])) blk = 1'b0;
            end
        end
`endif
        if (blk) return {8'hFF, 4'hF};
        s = font[nib_of(c, d)];
        if (c[16+d]) s[7] = 1'b0;
        return {s, ~(4'b0001 << d)};
    endfunction

    // Advance one edge; the model uses the pre-edge state, exactly as the registered display does.
    task automatic tick();
        @(posedge clk_100mhz);
        if (rst) begin
            {exp_seg, exp_an} = {8'hFF, 4'hF};
            m_ctrl = 24'h0;
            m_cyc  = 0;
        end else begin
            {exp_seg, exp_an} = ref_disp(m_ctrl, (m_cyc / DIV) % 4);
            if (ce_i && we_i) begin
                for (int b = 0; b < 3; b++)
                    if (sel_i[b]) m_ctrl[8*b +: 8] = data_i[8*b +: 8];
            end
            m_cyc++;
        end
        #1;
    endtask

    task automatic bus_write(input logic [3:0] s, input logic [31:0] d);
        ce_i = 1'b1; we_i = 1'b1; sel_i = s; data_i = d;
        tick();
        ce_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce_i = 1'b1; we_i = 1'b1; sel_i = 4'hF; data_i = 32'hFFFF_FFFF;
        repeat (3) tick();
        checks++;
        if (seg !== 8'hFF || an !== 4'hF)
            $display("FAIL reset_out: seg=%h an=%h expected FF/F", seg, an);
        if (seg !== 8'hFF || an !== 4'hF) errors++;
        rst = 1'b0; we_i = 1'b0; #1;
        checks++;
        if (data_o !== 32'h0) begin
            errors++; $display("FAIL reset_read: data_o=%h expected 00000000", data_o);
        end
        ce_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (seg !== 8'hFF || an !== 4'hF) begin
                errors++; $display("FAIL reset_blank: cycle %0d seg=%h an=%h expected FF/F", i, seg, an);
            end
        end
    endtask

    task automatic test_write_read();
        int hits;
        logic [7:0] want;
        bus_write(4'b0111, 32'h00F0_1234);
        ce_i = 1'b1; #1;
        checks++;
        if (data_o !== 32'h00F0_1234) begin
            errors++; $display("FAIL write_read: data_o=%h expected 00F01234", data_o);
        end
        ce_i = 1'b0;
        hits = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            checks++;
            if ({seg, an} !== {exp_seg, exp_an}) begin
                errors++; $display("FAIL write_scan: seg=%h an=%h expected %h/%h", seg, an, exp_seg, exp_an);
            end
            case (an)
                4'hE: want = 8'h99;
                4'hD: want = 8'hB0;
                4'hB: want = 8'hA4;
                4'h7: want = 8'hF9;
                default: want = 8'h00;
            endcase
            if (want != 8'h00) begin
                hits++;
                checks++;
                if (seg !== want) begin
                    errors++; $display("FAIL write_font: an=%h seg=%h expected %h", an, seg, want);
                end
            end
        end
        checks++;
        if (hits != 24) begin
            errors++; $display("FAIL write_slots: lit cycles=%0d expected 24", hits);
        end
    endtask

    task automatic test_byte_write();
        bus_write(4'b0001, 32'hFFFF_FFAB);
        ce_i = 1'b1; #1;
        checks++;
        if (data_o !== 32'h00F0_12AB) begin
            errors++; $display("FAIL byte_read: data_o=%h expected 00F012AB", data_o);
        end
        ce_i = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            checks++;
            if ({seg, an} !== {exp_seg, exp_an}) begin
                errors++; $display("FAIL byte_scan: seg=%h an=%h expected %h/%h", seg, an, exp_seg, exp_an);
            end
            if (an == 4'hE || an == 4'hD) begin
                checks++;
                if (seg !== ((an == 4'hE) ? 8'h83 : 8'h88)) begin
                    errors++; $display("FAIL byte_font: an=%h seg=%h", an, seg);
                end
            end
        end
    endtask

    task automatic test_disabled();
        bus_write(4'b0111, 32'h0010_0008);
        for (int i = 0; i < 24; i++) begin
            tick();
            checks++;
            if ({seg, an} !== {exp_seg, exp_an}) begin
                errors++; $display("FAIL dis_scan: seg=%h an=%h expected %h/%h", seg, an, exp_seg, exp_an);
            end
            checks++;
            if (!((an == 4'hE && seg == 8'h80) || (an == 4'hF && seg == 8'hFF))) begin
                errors++; $display("FAIL dis_slot: seg=%h an=%h expected 80/E or FF/F", seg, an);
            end
        end
        bus_write(4'b0111, 32'h0031_0008);
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if ({seg, an} !== {exp_seg, exp_an}) begin
                errors++; $display("FAIL dis_dp: seg=%h an=%h expected %h/%h", seg, an, exp_seg, exp_an);
            end
        end
    endtask

    task automatic test_lzb();
        bus_write(4'b0111, 32'h00F2_0007);
        for (int i = 0; i < 24; i++) begin
            tick();
            checks++;
            if ({seg, an} !== {exp_seg, exp_an}) begin
                errors++; $display("FAIL lzb_scan: seg=%h an=%h expected %h/%h", seg, an, exp_seg, exp_an);
            end
            if (an == 4'hE || an == 4'hD) begin
                checks++;
                if (seg !== ((an == 4'hE) ? 8'hF8 : 8'h40)) begin
                    errors++; $display("FAIL lzb_low: an=%h seg=%h", an, seg);
                end
            end
`ifdef SEG_LZB_EN
            checks++;
            if (an == 4'hB || an == 4'h7) begin
                errors++; $display("FAIL lzb_blank: an=%h expected digits 3,2 blank", an);
            end
`else
            if (an == 4'hB || an == 4'h7) begin
                checks++;
                if (seg !== 8'hC0) begin
                    errors++; $display("FAIL lzb_zero: an=%h seg=%h expected C0", an, seg);
                end
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 240; i++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    ce_i = 1'b1; we_i = 1'b1;
                    sel_i = 4'($urandom_range(0, 15));
                    data_i = $urandom();
                    if ($urandom_range(0, 1) == 1) data_i[15:4] = 12'h0;
                    if ($urandom_range(0, 2) == 0) data_i[19:16] = 4'h0;
                end
                2: begin
                    ce_i = 1'b1; we_i = 1'b0; data_i = $urandom(); #1;
                    checks++;
                    if (data_o !== {8'h00, m_ctrl}) begin
                        errors++; $display("FAIL rand_read: data_o=%h expected %h", data_o, {8'h00, m_ctrl});
                    end
                end
                default: begin
                    ce_i = 1'b0; we_i = 1'($urandom_range(0, 1)); data_i = $urandom(); #1;
                    checks++;
                    if (data_o !== 32'h0) begin
                        errors++; $display("FAIL rand_idle: data_o=%h expected 00000000", data_o);
                    end
                end
            endcase
            tick();
            checks++;
            if ({seg, an} !== {exp_seg, exp_an}) begin
                errors++; $display("FAIL rand_scan: cycle %0d seg=%h an=%h expected %h/%h", i, seg, an, exp_seg, exp_an);
            end
            checks++;
            if ($countones(~an) > 1) begin
                errors++; $display("FAIL rand_onehot: an=%h expected at most one low", an);
            end
        end
        ce_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int guard;
        bus_write(4'b0111, 32'h00F0_1234);
        guard = 0;
        while (((m_cyc / DIV) % 4) != 2 && guard < 64) begin
            tick();
            guard++;
        end
        tick();
        rst = 1'b1; ce_i = 1'b1; we_i = 1'b1; sel_i = 4'hF; data_i = $urandom();
        tick();
        checks++;
        if (seg !== 8'hFF || an !== 4'hF) begin
            errors++; $display("FAIL mid_reset: seg=%h an=%h expected FF/F", seg, an);
        end
        rst = 1'b0; we_i = 1'b0; #1;
        checks++;
        if (data_o !== 32'h0) begin
            errors++; $display("FAIL mid_ctrl: data_o=%h expected 00000000", data_o);
        end
        bus_write(4'b0111, 32'h00F0_1234);
        checks++;
        if (seg !== 8'hFF || an !== 4'hF) begin
            errors++; $display("FAIL mid_blank: seg=%h an=%h expected FF/F", seg, an);
        end
        tick();
        checks++;
        if (seg !== 8'h99 || an !== 4'hE) begin
            errors++; $display("FAIL mid_restart: seg=%h an=%h expected 99/E", seg, an);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if ({seg, an} !== {exp_seg, exp_an}) begin
                errors++; $display("FAIL mid_scan: seg=%h an=%h expected %h/%h", seg, an, exp_seg, exp_an);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_disabled();
        test_lzb();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
